// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and baud divisor helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Rounded to the nearest whole clock so the bit rate error stays under half a cycle.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered show-ahead FIFO shared by the UART transmit and receive paths
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter driving the TXD pin
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e               state_q;
  logic [BW-1:0]             baud_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      txd_q;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      bit_done;
  logic [UART_DATA_BITS-1:0] head;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bit_done = (baud_q == BAUD_LAST);
  // STOP pops on its last cycle so consecutive frames abut with no idle bit.
  assign pop      = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  assign wr_ready = !fifo_full;
  assign TXD      = txd_q;
  assign busy     = (state_q != IDLE) || (fifo_level != '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            state_q <= START;
            shift_q <= head;
            baud_q  <= '0;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            baud_q    <= '0;
            txd_q     <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= START;
              shift_q <= head;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a frame-timeline model
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1000;
  localparam int BAUD_R = 100;
  localparam int DEPTH  = 4;
  localparam int CPB    = (CLK_HZ + BAUD_R / 2) / BAUD_R;
  localparam int FRAME  = 10 * CPB;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       TXD;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Each accepted byte: the edge it was written, the edge its frame starts, and its value.
  int         m_wr[$];
  int         m_start[$];
  logic [7:0] m_dat[$];

  uart_tx_fifo #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_R),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .TXD        (TXD),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 CLK = ~CLK;

  function automatic int model_level(input int t);
    int n = 0;
    foreach (m_wr[i]) if (m_wr[i] <= t && m_start[i] > t) n++;
    return n;
  endfunction

  // Line value during the cycle after edge t, or -1 when no frame is on the line.
  function automatic int model_line(input int t);
    foreach (m_start[i]) begin
      if (t >= m_start[i] && t < m_start[i] + FRAME) begin
        int b = (t - m_start[i]) / CPB;
        if (b == 0) return 0;
        if (b == 9) return 1;
        return int'(m_dat[i][b-1]);
      end
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    int lvl;
    int ln;
    int first;
    @(posedge CLK);
    cyc++;
    if (RESET) begin
      m_wr.delete();
      m_start.delete();
      m_dat.delete();
    end else if (wr_valid) begin
      lvl = 0;
      foreach (m_wr[i]) if (m_wr[i] < cyc && m_start[i] >= cyc) lvl++;
      if (lvl < DEPTH) begin
        first = cyc + 1;
        if (m_start.size() > 0 && m_start[$] + FRAME > first) first = m_start[$] + FRAME;
        m_wr.push_back(cyc);
        m_start.push_back(first);
        m_dat.push_back(wr_data);
      end
    end
    #1;
    lvl = model_level(cyc);
    ln  = model_line(cyc);
    check("txd", 32'(TXD), 32'((ln < 0) ? 1 : ln));
    check("fifo_level", 32'(fifo_level), 32'(lvl));
    check("wr_ready", 32'(wr_ready), 32'(lvl != DEPTH));
    check("busy", 32'(busy), 32'((lvl != 0) || (ln >= 0)));
  endtask

  task automatic put(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
  endtask

  initial begin
    int w;

    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    repeat (200) tick();

    put(8'hA5);
    wr_valid = 1'b0;
    repeat (110) tick();

    put(8'h41);
    put(8'h42);
    put(8'h43);
    wr_valid = 1'b0;
    repeat (310) tick();

    repeat (6) put(8'($urandom));
    wr_valid = 1'b0;
    repeat (620) tick();

    // Hold the FIFO full so every STOP-end pop coincides with a dropped write.
    repeat (300) put(8'($urandom));
    wr_valid = 1'b0;
    repeat (520) tick();

    put(8'hFF);
    w = cyc;
    put(8'($urandom));
    put(8'($urandom));
    wr_valid = 1'b0;
    while (cyc < w + 1 + 4 * CPB + CPB / 2 - 1) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    repeat (300) tick();

    repeat (3000) begin
      wr_valid = ($urandom_range(0, 99) < 15);
      wr_data  = 8'($urandom);
      RESET    = ($urandom_range(0, 499) == 0);
      tick();
    end
    wr_valid = 1'b0;
    RESET    = 1'b0;
    repeat (600) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
